// File: rtl/instruction_fetcher_if.sv
// -----------------------------------------------------------------------------
// instruction_fetcher_if
// Bundles the fetch request, the memory read port and the fetch result of the
// instruction fetcher.
//   start, pc         : fetch request and instruction start address
//   mem_addr          : byte address presented to memory
//   mem_data          : byte returned combinationally by memory for mem_addr
//   instruction       : last completed instruction
//   next_pc           : address following the last completed instruction
//   done              : one-cycle pulse, instruction/next_pc newly valid
//   busy              : fetch in progress
// Modports:
//   master : requester plus memory side (drives start, pc, mem_data)
//   slave  : the fetcher itself
// -----------------------------------------------------------------------------
interface instruction_fetcher_if #(
  parameter int ADDR_W  = 13,
  parameter int INSTR_W = 19
);
  logic               start;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_data;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  next_pc;
  logic               done;
  logic               busy;

  modport master (
    output start, pc, mem_data,
    input  mem_addr, instruction, next_pc, done, busy
  );

  modport slave (
    input  start, pc, mem_data,
    output mem_addr, instruction, next_pc, done, busy
  );
endinterface

// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
// Reads three consecutive bytes starting at pc from a byte-wide memory with a
// combinational read path and assembles them, big-endian, into one
// INSTR_W-bit instruction. One address is issued per cycle; the returned byte
// is captured on the following rising edge.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : instruction_fetcher_if.slave (start, pc, mem_addr, mem_data,
//         instruction, next_pc, done, busy)
// -----------------------------------------------------------------------------
module instruction_fetcher #(
  parameter int ADDR_W  = 13,
  parameter int INSTR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_fetcher_if.slave  bus
);

  // Number of bits of the first byte that land in the instruction.
  localparam int HI_W = INSTR_W - 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FETCH2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base;
  logic [7:0]         hi_byte;
  logic [7:0]         mid_byte;
  logic [INSTR_W-1:0] instruction_q;
  logic [ADDR_W-1:0]  next_pc_q;
  logic               done_q;
  logic               busy_q;
  logic [ADDR_W-1:0]  mem_addr_c;

  // Address offset with wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        off);
    return a + ADDR_W'(off);
  endfunction

  // Big-endian assembly; the unused upper bits of the first byte are dropped.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [7:0] hi,
                                                    input logic [7:0] mid,
                                                    input logic [7:0] lo);
    return {hi[HI_W-1:0], mid, lo};
  endfunction

  // Memory address is combinational from state and base.
  always_comb begin
    mem_addr_c = base;
    case (state)
      FETCH1:  mem_addr_c = addr_add(base, 2'd1);
      FETCH2:  mem_addr_c = addr_add(base, 2'd2);
      default: mem_addr_c = base;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      base          <= '0;
      hi_byte       <= '0;
      mid_byte      <= '0;
      instruction_q <= '0;
      next_pc_q     <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            base   <= bus.pc;
            busy_q <= 1'b1;
            state  <= FETCH0;
          end
        end
        FETCH0: begin
          hi_byte <= bus.mem_data;
          state   <= FETCH1;
        end
        FETCH1: begin
          mid_byte <= bus.mem_data;
          state    <= FETCH2;
        end
        FETCH2: begin
          // Instruction and next_pc update together so no partial result is visible.
          instruction_q <= pack_instr(hi_byte, mid_byte, bus.mem_data);
          next_pc_q     <= addr_add(base, 2'd3);
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state         <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            base   <= bus.pc;
            busy_q <= 1'b1;
            state  <= FETCH0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.instruction = instruction_q;
  assign bus.next_pc     = next_pc_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

  localparam int ADDR_W  = 13;
  localparam int INSTR_W = 19;

  logic clk;
  logic rst;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int n_checks;
  int n_pass;
  int n_fail;

  instruction_fetcher_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instruction_fetcher #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational memory model
  assign bus.mem_data = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single fetch from IDLE/DONE with hand-computed expected results.
  task automatic fetch(input string tag, input logic [ADDR_W-1:0] p,
                       input logic [INSTR_W-1:0] exp_instr,
                       input logic [ADDR_W-1:0] exp_npc);
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    a1 = p + 13'd1;
    a2 = p + 13'd2;
    bus.start = 1'b1;
    bus.pc    = p;
    tick();
    bus.start = 1'b0;
    check({tag, " busy f0"}, {31'd0, bus.busy}, 32'd1);
    check({tag, " addr f0"}, {19'd0, bus.mem_addr}, {19'd0, p});
    tick();
    check({tag, " addr f1"}, {19'd0, bus.mem_addr}, {19'd0, a1});
    tick();
    check({tag, " addr f2"}, {19'd0, bus.mem_addr}, {19'd0, a2});
    check({tag, " done f2"}, {31'd0, bus.done}, 32'd0);
    tick();
    check({tag, " done"},  {31'd0, bus.done}, 32'd1);
    check({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " instr"}, {13'd0, bus.instruction}, {13'd0, exp_instr});
    check({tag, " next_pc"}, {19'd0, bus.next_pc}, {19'd0, exp_npc});
    tick();
    check({tag, " done fall"}, {31'd0, bus.done}, 32'd0);
    check({tag, " instr hold"}, {13'd0, bus.instruction}, {13'd0, exp_instr});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    mem[8]    = 8'b0000_0101;
    mem[9]    = 8'hA3;
    mem[10]   = 8'h3C;
    mem[20]   = 8'hFD;
    mem[21]   = 8'h00;
    mem[22]   = 8'h01;
    mem[8190] = 8'h02;
    mem[8191] = 8'h11;
    mem[0]    = 8'h22;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.pc    = '0;

    // Reset values before any clock edge
    #2;
    check("rst instr",    {13'd0, bus.instruction}, 32'd0);
    check("rst next_pc",  {19'd0, bus.next_pc}, 32'd0);
    check("rst done",     {31'd0, bus.done}, 32'd0);
    check("rst busy",     {31'd0, bus.busy}, 32'd0);
    check("rst mem_addr", {19'd0, bus.mem_addr}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    fetch("basic", 13'd8, 19'h5A33C, 13'd11);

    // Asynchronous reset in FETCH1 clears everything without an edge
    bus.start = 1'b1;
    bus.pc    = 13'd20;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid addr f1", {19'd0, bus.mem_addr}, 32'd21);
    rst = 1'b0;
    #1;
    check("async instr",    {13'd0, bus.instruction}, 32'd0);
    check("async next_pc",  {19'd0, bus.next_pc}, 32'd0);
    check("async done",     {31'd0, bus.done}, 32'd0);
    check("async busy",     {31'd0, bus.busy}, 32'd0);
    check("async mem_addr", {19'd0, bus.mem_addr}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post rst done", {31'd0, bus.done}, 32'd0);

    fetch("mask", 13'd20, 19'h50001, 13'd23);
    fetch("wrap", 13'd8190, 19'h21122, 13'd1);

    // Back-to-back with start held; pc change while busy must be ignored
    bus.start = 1'b1;
    bus.pc    = 13'd8;
    tick();
    check("b2b busy", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.pc = 13'd20;
    check("b2b addr f1", {19'd0, bus.mem_addr}, 32'd9);
    tick();
    check("b2b addr f2", {19'd0, bus.mem_addr}, 32'd10);
    tick();
    check("b2b done1",  {31'd0, bus.done}, 32'd1);
    check("b2b instr1", {13'd0, bus.instruction}, 32'h5A33C);
    check("b2b npc1",   {19'd0, bus.next_pc}, 32'd11);
    tick();
    check("b2b done1 fall", {31'd0, bus.done}, 32'd0);
    check("b2b busy2",      {31'd0, bus.busy}, 32'd1);
    check("b2b addr2 f0",   {19'd0, bus.mem_addr}, 32'd20);
    bus.start = 1'b0;
    tick();
    tick();
    check("b2b instr hold", {13'd0, bus.instruction}, 32'h5A33C);
    tick();
    check("b2b done2",  {31'd0, bus.done}, 32'd1);
    check("b2b instr2", {13'd0, bus.instruction}, 32'h50001);
    check("b2b npc2",   {19'd0, bus.next_pc}, 32'd23);
    tick();
    check("b2b idle", {31'd0, bus.done}, 32'd0);

    // Abort in FETCH2: no done pulse, result stays at reset value
    bus.start = 1'b1;
    bus.pc    = 13'd8;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort addr f2", {19'd0, bus.mem_addr}, 32'd10);
    rst = 1'b0;
    #1;
    check("abort instr", {13'd0, bus.instruction}, 32'd0);
    tick();
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    tick();
    check("abort done2",  {31'd0, bus.done}, 32'd0);
    check("abort instr2", {13'd0, bus.instruction}, 32'd0);

    fetch("after abort", 13'd8, 19'h5A33C, 13'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Fetch stage that sits directly upstream of the byte-wide shared instruction/data memory. On a start request it reads three consecutive bytes at the program counter and assembles them into one 19-bit instruction for the control unit. The memory read path is combinational (address in, byte out, same cycle), so the fetcher issues one address per cycle and captures the returned byte on the next rising clock edge.

## Interface
- ADDR_W, 13, memory byte-address width; all address arithmetic is modulo 2^ADDR_W
- INSTR_W, 19, instruction width; legal range 17..24, always occupies exactly 3 bytes
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-low (rst=0 resets immediately, independent of clk)
- start  input  1  fetch request, sampled on rising clk edge
- pc  input  ADDR_W  byte address of the instruction's first byte, sampled with start
- mem_addr  output  ADDR_W  address driven to the memory
- mem_data  input  8  byte returned combinationally by the memory for mem_addr
- instruction  output  INSTR_W  last completed instruction, registered
- next_pc  output  ADDR_W  registered (pc + 3) mod 2^ADDR_W of the last completed fetch
- done  output  1  one-cycle pulse: instruction and next_pc are newly valid
- busy  output  1  high in FETCH0/FETCH1/FETCH2

## Operation
- Byte layout, big-endian: byte at pc supplies instruction[INSTR_W-1:16] from its low INSTR_W-16 bits (upper bits ignored); pc+1 supplies [15:8]; pc+2 supplies [7:0].
- FSM states: IDLE, FETCH0, FETCH1, FETCH2, DONE.
- IDLE: start=1 latches pc into base register -> FETCH0; otherwise stay.
- FETCH0: mem_addr=base; edge captures mem_data into hi byte -> FETCH1.
- FETCH1: mem_addr=base+1; edge captures mid byte -> FETCH2.
- FETCH2: mem_addr=base+2; edge loads instruction with {hi,mid,mem_data} and next_pc with base+3, atomically -> DONE.
- DONE: done=1. start=1 latches new pc -> FETCH0 (back-to-back); else -> IDLE.
- mem_addr in IDLE and DONE equals base. mem_addr is combinational from state and base; address additions wrap mod 2^ADDR_W.
- start while busy=1 is ignored and not queued; pc is not resampled.
- instruction and next_pc hold their values until the next FETCH2 edge; partial bytes never appear on instruction.
- The fetcher never writes memory; it drives no write enable.

## Timing
- Reset values: state IDLE, base 0, mem_addr 0, instruction 0, next_pc 0, done 0, busy 0.
- start sampled at edge N -> busy high from N to N+3; bytes captured at N+1, N+2, N+3; instruction/next_pc update and done rises at edge N+3; done falls at N+4.
- Latency start-to-done: 3 cycles. Sustained throughput with start held high: one instruction per 4 cycles.
- rst asserted mid-fetch: immediate return to IDLE, all outputs to reset values, no done pulse; captured bytes are discarded.
- rst deasserted with start=1 on the first edge: the fetch is accepted normally.
- mem_data must be stable for the setup time before each capture edge; mem_addr changes only just after edges.

## Test plan
- Reset: rst=0 with state FETCH1 -> instruction=0, next_pc=0, done=0, busy=0, mem_addr=0 immediately, before any clk edge.
- Basic fetch: mem[8]=8'b00000101, mem[9]=8'hA3, mem[10]=8'h3C, pc=8, start pulse -> mem_addr sequence 8,9,10; after 3 cycles done=1 for one cycle, instruction=19'h5A33C, next_pc=11.
- Upper-bit masking: mem[20]=8'hFD, mem[21]=8'h00, mem[22]=8'h01, pc=20 -> instruction=19'h50001.
- Wrap-around: pc=8190, mem[8190]=8'h02, mem[8191]=8'h11, mem[0]=8'h22 -> mem_addr 8190,8191,0; instruction=19'h21122, next_pc=1.
- Busy ignore and back-to-back: start held high from pc=8, pc changed to 20 during FETCH1 -> first result 19'h5A33C from pc=8; start is re-accepted in DONE with pc=20, giving 19'h50001 exactly 4 cycles after the first done.
- Abort: rst pulsed during FETCH2 -> no done pulse, instruction stays 0; a new start then completes normally.
